// File: rtl/axi_rd_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axi_rd_arbiter_if                                            |
// | Description : Requester-side and memory-side AXI read signals of the read  |
// |               arbiter. The slave modport is the arbiter's view.            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface axi_rd_arbiter_if #(
    parameter int MST_N = 3,
    parameter int ID_W  = 4
);
    // Requester side
    logic [MST_N-1:0]      m_arvalid;
    logic [MST_N-1:0]      m_arready;
    logic [MST_N*32-1:0]   m_araddr;
    logic [MST_N*ID_W-1:0] m_arid;
    logic [MST_N*3-1:0]    m_arsize;
    logic [MST_N*8-1:0]    m_arlen;
    logic [MST_N*2-1:0]    m_arburst;
    logic [MST_N-1:0]      m_rvalid;
    logic [MST_N-1:0]      m_rready;
    logic [31:0]           m_rdata;
    logic [1:0]            m_rresp;
    logic                  m_rlast;

    // Memory side
    logic                  s_arvalid;
    logic                  s_arready;
    logic [31:0]           s_araddr;
    logic [ID_W-1:0]       s_arid;
    logic [2:0]            s_arsize;
    logic [7:0]            s_arlen;
    logic [1:0]            s_arburst;
    logic                  s_rvalid;
    logic                  s_rready;
    logic [31:0]           s_rdata;
    logic [1:0]            s_rresp;
    logic                  s_rlast;
    logic [ID_W-1:0]       s_rid;

    modport slave (
        input  m_arvalid, m_araddr, m_arid, m_arsize, m_arlen, m_arburst, m_rready,
        output m_arready, m_rvalid, m_rdata, m_rresp, m_rlast,
        output s_arvalid, s_araddr, s_arid, s_arsize, s_arlen, s_arburst, s_rready,
        input  s_arready, s_rvalid, s_rdata, s_rresp, s_rlast, s_rid
    );

    modport master (
        output m_arvalid, m_araddr, m_arid, m_arsize, m_arlen, m_arburst, m_rready,
        input  m_arready, m_rvalid, m_rdata, m_rresp, m_rlast,
        input  s_arvalid, s_araddr, s_arid, s_arsize, s_arlen, s_arburst, s_rready,
        output s_arready, s_rvalid, s_rdata, s_rresp, s_rlast, s_rid
    );
endinterface
`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axi_rd_arbiter                                               |
// | Description : Merges MST_N AXI read requesters onto one memory read port,  |
// |               one transaction at a time (grant, forward AR, route R).      |
// |               Define ARB_RR_EN for round-robin; default is fixed priority. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module axi_rd_arbiter #(
    parameter int MST_N = 3,
    parameter int ID_W  = 4
) (
    input  wire logic       clock,
    input  wire logic       reset,
    axi_rd_arbiter_if.slave bus
);
    localparam int GRANT_W = (MST_N > 1) ? $clog2(MST_N) : 1;

    localparam logic [2:0] ST_IDLE = 3'b001;
    localparam logic [2:0] ST_AR   = 3'b010;
    localparam logic [2:0] ST_R    = 3'b100;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [GRANT_W-1:0] r_grant;
    logic [GRANT_W-1:0] w_winner;
    logic               w_any;
    logic [MST_N-1:0]   w_grant_oh;
    logic               w_grant_rready;
    logic               w_beat_xfer;

    logic [31:0]        r_araddr;
    logic [ID_W-1:0]    r_arid;
    logic [2:0]         r_arsize;
    logic [7:0]         r_arlen;
    logic [1:0]         r_arburst;

    logic [31:0]        w_sel_addr;
    logic [ID_W-1:0]    w_sel_id;
    logic [2:0]         w_sel_size;
    logic [7:0]         w_sel_len;
    logic [1:0]         w_sel_burst;

    assign w_any = |bus.m_arvalid;

`ifdef ARB_RR_EN
    logic [GRANT_W-1:0] r_last_grant;
    int                 w_best;
    int                 w_dist;

    // Distance 0 is the requester just after last_grant, wrapping MST_N-1 -> 0.
    always_comb begin
        w_winner = '0;
        w_best   = MST_N;
        w_dist   = 0;
        for (int i = 0; i < MST_N; i++) begin
            w_dist = (i + MST_N - 1 - int'(r_last_grant)) % MST_N;
            if (bus.m_arvalid[i] && (w_dist < w_best)) begin
                w_best   = w_dist;
                w_winner = GRANT_W'(i);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_last_grant <= '0;
        end else if ((r_state == ST_AR) && bus.s_arready) begin
            r_last_grant <= r_grant;
        end
    end
`else
    always_comb begin
        w_winner = '0;
        for (int i = MST_N - 1; i >= 0; i--) begin
            if (bus.m_arvalid[i]) begin
                w_winner = GRANT_W'(i);
            end
        end
    end
`endif

    always_comb begin
        w_sel_addr  = '0;
        w_sel_id    = '0;
        w_sel_size  = '0;
        w_sel_len   = '0;
        w_sel_burst = '0;
        for (int i = 0; i < MST_N; i++) begin
            if (w_winner == GRANT_W'(i)) begin
                w_sel_addr  = bus.m_araddr[32*i +: 32];
                w_sel_id    = bus.m_arid[ID_W*i +: ID_W];
                w_sel_size  = bus.m_arsize[3*i +: 3];
                w_sel_len   = bus.m_arlen[8*i +: 8];
                w_sel_burst = bus.m_arburst[2*i +: 2];
            end
        end
    end

    always_comb begin
        w_grant_oh = '0;
        for (int i = 0; i < MST_N; i++) begin
            w_grant_oh[i] = (r_grant == GRANT_W'(i));
        end
    end

    assign w_grant_rready = |(bus.m_rready & w_grant_oh);
    assign w_beat_xfer    = bus.s_rvalid && w_grant_rready;

    // Grant and AR payload are captured once in IDLE and held for the transaction.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_grant   <= '0;
            r_araddr  <= '0;
            r_arid    <= '0;
            r_arsize  <= '0;
            r_arlen   <= '0;
            r_arburst <= '0;
        end else if ((r_state == ST_IDLE) && w_any) begin
            r_grant   <= w_winner;
            r_araddr  <= w_sel_addr;
            r_arid    <= w_sel_id;
            r_arsize  <= w_sel_size;
            r_arlen   <= w_sel_len;
            r_arburst <= w_sel_burst;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any)                          w_state_nxt = ST_AR;
            ST_AR:   if (bus.s_arready)                  w_state_nxt = ST_R;
            ST_R:    if (w_beat_xfer && bus.s_rlast)     w_state_nxt = ST_IDLE;
            default:                                     w_state_nxt = ST_IDLE;
        endcase
    end

    // Outside ST_R the memory R channel is stalled rather than drained.
    always_comb begin
        bus.s_arvalid = 1'b0;
        bus.m_arready = '0;
        bus.s_rready  = 1'b0;
        bus.m_rvalid  = '0;
        bus.m_rdata   = '0;
        bus.m_rresp   = '0;
        bus.m_rlast   = 1'b0;
        case (r_state)
            ST_AR: begin
                bus.s_arvalid = 1'b1;
                if (bus.s_arready) begin
                    bus.m_arready = w_grant_oh;
                end
            end
            ST_R: begin
                bus.s_rready = w_grant_rready;
                bus.m_rvalid = bus.s_rvalid ? w_grant_oh : '0;
                bus.m_rdata  = bus.s_rdata;
                bus.m_rresp  = bus.s_rresp;
                bus.m_rlast  = bus.s_rlast;
            end
            default: ;
        endcase
    end

    assign bus.s_araddr  = r_araddr;
    assign bus.s_arid    = r_arid;
    assign bus.s_arsize  = r_arsize;
    assign bus.s_arlen   = r_arlen;
    assign bus.s_arburst = r_arburst;

    // Single outstanding transaction, so every returned beat must carry the issued id.
    a_rid_match: assert property (@(posedge clock) disable iff (!reset)
        ((r_state == ST_R) && bus.s_rvalid) |-> (bus.s_rid == r_arid));

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_axi_rd_arbiter                                            |
// | Description : Directed self-checking bench for axi_rd_arbiter.             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_axi_rd_arbiter;
    localparam int MST_N = 3;
    localparam int ID_W  = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clock = ~clock;

    axi_rd_arbiter_if #(.MST_N(MST_N), .ID_W(ID_W)) bus ();

    axi_rd_arbiter #(.MST_N(MST_N), .ID_W(ID_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.m_arvalid = '0;
        bus.m_araddr  = '0;
        bus.m_arid    = '0;
        bus.m_arsize  = '0;
        bus.m_arlen   = '0;
        bus.m_arburst = '0;
        bus.m_rready  = '0;
        bus.s_arready = 1'b0;
        bus.s_rvalid  = 1'b0;
        bus.s_rdata   = '0;
        bus.s_rresp   = '0;
        bus.s_rlast   = 1'b0;
        bus.s_rid     = '0;
    endtask

    task automatic set_req(input int i, input logic [31:0] addr, input logic [3:0] id,
                           input logic [7:0] len);
        bus.m_araddr[32*i +: 32]    = addr;
        bus.m_arid[ID_W*i +: ID_W]  = id;
        bus.m_arlen[8*i +: 8]       = len;
        bus.m_arsize[3*i +: 3]      = 3'd2;
        bus.m_arburst[2*i +: 2]     = 2'b01;
        bus.m_arvalid[i]            = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
    endtask

    // One single-beat transaction for requester g, starting from IDLE with requests pending.
    task automatic one_txn(input int g, input bit drop, input logic [31:0] rdat);
        cyc();
        check("arb_s_araddr", bus.s_araddr, 32'h1000_0000 + 32'(g) * 32'h100);
        check("arb_m_arready", bus.m_arready, 64'(1 << g));
        cyc();
        if (drop) bus.m_arvalid[g] = 1'b0;
        bus.s_rvalid = 1'b1;
        bus.s_rdata  = rdat;
        bus.s_rlast  = 1'b1;
        bus.s_rid    = 4'(g);
        bus.m_rready = '1;
        #1;
        check("arb_m_rvalid", bus.m_rvalid, 64'(1 << g));
        check("arb_m_rdata", bus.m_rdata, rdat);
        cyc();
        bus.s_rvalid = 1'b0;
        bus.s_rlast  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit pat [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int eb  [7] = '{0, 1, 1, 2, 2, 3, 3};
        int beat;
        int nxfer;

        // Reset state
        clear_inputs();
        #1;
        check("rst_s_arvalid", bus.s_arvalid, 1'b0);
        check("rst_m_arready", bus.m_arready, 3'b000);
        check("rst_m_rvalid", bus.m_rvalid, 3'b000);
        check("rst_s_rready", bus.s_rready, 1'b0);
        check("rst_s_araddr", bus.s_araddr, 32'h0);
        do_reset();

        // Single PTW read
        set_req(0, 32'h8000_1004, 4'h3, 8'd0);
        bus.s_arready = 1'b1;
        #1;
        check("t1_idle_arvalid", bus.s_arvalid, 1'b0);
        cyc();
        check("t1_s_arvalid", bus.s_arvalid, 1'b1);
        check("t1_s_araddr", bus.s_araddr, 32'h8000_1004);
        check("t1_s_arid", bus.s_arid, 4'h3);
        check("t1_m_arready", bus.m_arready, 3'b001);
        cyc();
        bus.m_arvalid = '0;
        bus.s_rvalid  = 1'b1;
        bus.s_rdata   = 32'h2000_0401;
        bus.s_rlast   = 1'b1;
        bus.s_rresp   = 2'b10;
        bus.s_rid     = 4'h3;
        bus.m_rready  = 3'b001;
        #1;
        check("t1_m_rvalid", bus.m_rvalid, 3'b001);
        check("t1_m_rdata", bus.m_rdata, 32'h2000_0401);
        check("t1_m_rresp", bus.m_rresp, 2'b10);
        check("t1_m_rlast", bus.m_rlast, 1'b1);
        check("t1_s_rready", bus.s_rready, 1'b1);
        check("t1_r_arready", bus.m_arready, 3'b000);
        cyc();
        check("t1_stray_s_rready", bus.s_rready, 1'b0);
        check("t1_stray_m_rvalid", bus.m_rvalid, 3'b000);
        check("t1_idle_arvalid2", bus.s_arvalid, 1'b0);
        clear_inputs();

        // IFU burst of 4 with m_rready toggling
        set_req(2, 32'h9000_0000, 4'h2, 8'd3);
        bus.s_arready = 1'b1;
        cyc();
        check("t4_s_arlen", bus.s_arlen, 8'd3);
        check("t4_s_araddr", bus.s_araddr, 32'h9000_0000);
        check("t4_m_arready", bus.m_arready, 3'b100);
        cyc();
        bus.m_arvalid = '0;
        beat  = 0;
        nxfer = 0;
        for (int k = 0; k < 7; k++) begin
            bus.m_rready = {pat[k], 2'b00};
            bus.s_rvalid = 1'b1;
            bus.s_rdata  = 32'hA000_0000 + 32'(beat);
            bus.s_rlast  = (beat == 3);
            bus.s_rid    = 4'h2;
            #1;
            check("t4_s_rready", bus.s_rready, pat[k]);
            check("t4_m_rvalid", bus.m_rvalid, 3'b100);
            check("t4_m_rdata", bus.m_rdata, 32'hA000_0000 + 32'(eb[k]));
            check("t4_m_rlast", bus.m_rlast, (eb[k] == 3));
            if (bus.s_rready && bus.s_rvalid) nxfer++;
            cyc();
            if (pat[k]) beat++;
        end
        check("t4_beats", 32'(nxfer), 32'd4);
        check("t4_exit_s_rready", bus.s_rready, 1'b0);
        check("t4_exit_m_rvalid", bus.m_rvalid, 3'b000);
        clear_inputs();

        // AR back-pressure for 5 cycles
        set_req(1, 32'h4000_0040, 4'h1, 8'd0);
        cyc();
        for (int k = 0; k < 5; k++) begin
            check("t5_s_arvalid", bus.s_arvalid, 1'b1);
            check("t5_s_araddr", bus.s_araddr, 32'h4000_0040);
            check("t5_m_arready", bus.m_arready, 3'b000);
            cyc();
        end
        bus.s_arready = 1'b1;
        #1;
        check("t5_pulse", bus.m_arready, 3'b010);
        cyc();
        bus.m_arvalid = '0;
        check("t5_after_pulse", bus.m_arready, 3'b000);
        check("t5_r_arvalid", bus.s_arvalid, 1'b0);
        bus.s_rvalid = 1'b1;
        bus.s_rlast  = 1'b1;
        bus.s_rid    = 4'h1;
        bus.m_rready = 3'b010;
        cyc();
        clear_inputs();

        // Arbitration order with all three requesting
        do_reset();
        set_req(0, 32'h1000_0000, 4'd0, 8'd0);
        set_req(1, 32'h1000_0100, 4'd1, 8'd0);
        set_req(2, 32'h1000_0200, 4'd2, 8'd0);
        bus.s_arready = 1'b1;
`ifdef ARB_RR_EN
        one_txn(1, 1'b0, 32'hC000_0001);
        one_txn(2, 1'b0, 32'hC000_0002);
        one_txn(0, 1'b0, 32'hC000_0003);
        one_txn(1, 1'b0, 32'hC000_0004);
`else
        one_txn(0, 1'b1, 32'hC000_0001);
        one_txn(1, 1'b1, 32'hC000_0002);
        one_txn(2, 1'b1, 32'hC000_0003);
`endif
        clear_inputs();
        cyc();

        // Reset mid-burst, then a fresh request
        set_req(0, 32'h8000_2000, 4'h5, 8'd3);
        bus.s_arready = 1'b1;
        cyc();
        cyc();
        bus.m_arvalid = '0;
        bus.m_rready  = 3'b001;
        bus.s_rvalid  = 1'b1;
        bus.s_rdata   = 32'hB000_0000;
        bus.s_rid     = 4'h5;
        #1;
        check("t6_beat1", bus.m_rvalid, 3'b001);
        cyc();
        bus.s_rdata = 32'hB000_0001;
        #1;
        check("t6_beat2", bus.m_rvalid, 3'b001);
        reset = 1'b0;
        #1;
        check("t6_rst_m_rvalid", bus.m_rvalid, 3'b000);
        check("t6_rst_s_rready", bus.s_rready, 1'b0);
        check("t6_rst_s_arvalid", bus.s_arvalid, 1'b0);
        check("t6_rst_m_arready", bus.m_arready, 3'b000);
        check("t6_rst_s_araddr", bus.s_araddr, 32'h0);
        check("t6_rst_m_rdata", bus.m_rdata, 32'h0);
        clear_inputs();
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
        set_req(1, 32'h1000_0100, 4'd1, 8'd0);
        bus.s_arready = 1'b1;
        one_txn(1, 1'b1, 32'hD000_0001);
        check("t6_idle_after", bus.s_arvalid, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
